// File: rtl/fifo_pkg.sv
// fifo_pkg: definitions shared by the single-clock FIFO and its storage.
//   FIFO_MODE_STD / FIFO_MODE_FWFT : values for the FWFT read-mode parameter
//   clog2()       : ceiling log2 for tools without $clog2
//   ptr_is_full() : full decode on (AW+1)-bit wrap-bit pointers
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    // Pointers are zero-extended to 32 bits by the caller. Full means the wrap
    // bit (bit aw) differs while every address bit matches, i.e. the XOR of the
    // two pointers is exactly the wrap bit.
    function automatic logic ptr_is_full(input logic [31:0] wr_ptr,
                                         input logic [31:0] rd_ptr,
                                         input int          aw);
        logic [31:0] diff;
        diff = wr_ptr ^ rd_ptr;
        return (diff == (32'd1 << aw));
    endfunction

endpackage

// File: rtl/fifo_ram_sp.sv
// fifo_ram_sp: DEPTH x DATA_W storage, one synchronous write port and one
// asynchronous read port. Contents are never reset.
//   clk_i   : write clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data, combinational from raddr_i
module fifo_ram_sp
    import fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int AW     = clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock parametrised FIFO with occupancy count,
// programmable almost-full/almost-empty thresholds, overflow/underflow pulses
// and a choice of registered or first-word-fall-through read.
//   clk, rst                : clock, synchronous active-high reset
//   wr_en, data_in          : write request and data
//   rd_en                   : read request (pop of head word in FWFT mode)
//   data_out                : read data
//   wfull, rempty           : DEPTH / zero entries held
//   almost_full/almost_empty: count >= AF_LEVEL / count <= AE_LEVEL
//   count                   : occupancy 0..DEPTH
//   overflow, underflow     : one-cycle pulses for rejected write / read
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter  int DATA_W   = 8,
    parameter  int DEPTH    = 8,
    parameter  int AF_LEVEL = DEPTH - 2,
    parameter  int AE_LEVEL = 2,
    parameter  int FWFT     = 0,
    localparam int AW       = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rd_en,
    output logic [DATA_W-1:0] data_out,
    output logic              wfull,
    output logic              rempty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [AW:0]       count,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [AW:0] AF_THR = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_THR = (AW+1)'(AE_LEVEL);

    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              overflow_q, underflow_q;
    logic              wr_acc, rd_acc;
    logic [DATA_W-1:0] ram_rdata;

    // All flags decode straight from registered state.
    assign rempty       = (wr_ptr_q == rd_ptr_q);
    assign wfull        = ptr_is_full(32'(wr_ptr_q), 32'(rd_ptr_q), AW);
    assign almost_full  = (count_q >= AF_THR);
    assign almost_empty = (count_q <= AE_THR);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // Acceptance looks only at the current full/empty state, so a write into a
    // full FIFO stays rejected even when a read frees a slot in the same cycle.
    assign wr_acc = wr_en && !wfull;
    assign rd_acc = rd_en && !rempty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= wr_en && wfull;
            underflow_q <= rd_en && rempty;
        end
    end

    // Writes are suppressed during reset so the reset cycle has no side effects.
    fifo_ram_sp #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (wr_acc && !rst),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (data_in),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (ram_rdata)
    );

    generate
        if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
            // Head word is presented directly; meaningful only while !rempty.
            assign data_out = ram_rdata;
        end else begin : g_std
            logic [DATA_W-1:0] dout_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    dout_q <= '0;
                end else if (rd_acc) begin
                    dout_q <= ram_rdata;
                end
            end
            assign data_out = dout_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;

    localparam int DW = 8;
    localparam int DP = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read instance
    logic          rst0, wr0, rd0;
    logic [DW-1:0] din0, dout0;
    logic          full0, empty0, af0, ae0, ovf0, unf0;
    logic [3:0]    cnt0;

    // Fall-through instance
    logic          rst1, wr1, rd1;
    logic [DW-1:0] din1, dout1;
    logic          full1, empty1, af1, ae1, ovf1, unf1;
    logic [3:0]    cnt1;

    sync_fifo_param #(
        .DATA_W(DW), .DEPTH(DP), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)
    ) dut0 (
        .clk(clk), .rst(rst0), .wr_en(wr0), .data_in(din0), .rd_en(rd0),
        .data_out(dout0), .wfull(full0), .rempty(empty0), .almost_full(af0),
        .almost_empty(ae0), .count(cnt0), .overflow(ovf0), .underflow(unf0)
    );

    sync_fifo_param #(
        .DATA_W(DW), .DEPTH(DP), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1)
    ) dut1 (
        .clk(clk), .rst(rst1), .wr_en(wr1), .data_in(din1), .rd_en(rd1),
        .data_out(dout1), .wfull(full1), .rempty(empty1), .almost_full(af1),
        .almost_empty(ae1), .count(cnt1), .overflow(ovf1), .underflow(unf1)
    );

    // Reference model: a plain queue per instance plus expected pulse/data values
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    logic [DW-1:0] exp_dout0;
    logic          eo0, eu0, eo1, eu1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model0();
        bit full, empty;
        if (rst0) begin
            q0.delete();
            exp_dout0 = '0;
            eo0 = 1'b0;
            eu0 = 1'b0;
        end else begin
            full  = (q0.size() == DP);
            empty = (q0.size() == 0);
            eo0 = wr0 && full;
            eu0 = rd0 && empty;
            if (rd0 && !empty) exp_dout0 = q0.pop_front();
            if (wr0 && !full) q0.push_back(din0);
        end
    endtask

    task automatic model1();
        bit full, empty;
        if (rst1) begin
            q1.delete();
            eo1 = 1'b0;
            eu1 = 1'b0;
        end else begin
            full  = (q1.size() == DP);
            empty = (q1.size() == 0);
            eo1 = wr1 && full;
            eu1 = rd1 && empty;
            if (rd1 && !empty) void'(q1.pop_front());
            if (wr1 && !full) q1.push_back(din1);
        end
    endtask

    task automatic check_all();
        check("std_count",    32'(cnt0),   32'(q0.size()));
        check("std_rempty",   32'(empty0), 32'(q0.size() == 0));
        check("std_wfull",    32'(full0),  32'(q0.size() == DP));
        check("std_afull",    32'(af0),    32'(q0.size() >= 6));
        check("std_aempty",   32'(ae0),    32'(q0.size() <= 2));
        check("std_overflow", 32'(ovf0),   32'(eo0));
        check("std_underflow",32'(unf0),   32'(eu0));
        check("std_data_out", 32'(dout0),  32'(exp_dout0));
        check("ft_count",     32'(cnt1),   32'(q1.size()));
        check("ft_rempty",    32'(empty1), 32'(q1.size() == 0));
        check("ft_wfull",     32'(full1),  32'(q1.size() == DP));
        check("ft_afull",     32'(af1),    32'(q1.size() >= 6));
        check("ft_aempty",    32'(ae1),    32'(q1.size() <= 2));
        check("ft_overflow",  32'(ovf1),   32'(eo1));
        check("ft_underflow", 32'(unf1),   32'(eu1));
        if (q1.size() != 0) check("ft_data_out", 32'(dout1), 32'(q1[0]));
    endtask

    // One clock: inputs already driven; sample 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        model0();
        model1();
        check_all();
    endtask

    task automatic idle_inputs();
        rst0 = 0; wr0 = 0; rd0 = 0; din0 = '0;
        rst1 = 0; wr1 = 0; rd1 = 0; din1 = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        eo0 = 0; eu0 = 0; eo1 = 0; eu1 = 0; exp_dout0 = '0;

        // Reset, then idle
        rst0 = 1; rst1 = 1;
        step();
        check("reset_count0", 32'(cnt0), 32'd0);
        check("reset_dout0",  32'(dout0), 32'd0);
        idle_inputs();
        step();

        // Fill with 0x11..0x88, one extra write of 0x99 must be rejected
        for (int i = 0; i < 8; i++) begin
            wr0 = 1; din0 = 8'(8'h11 * (i + 1));
            step();
        end
        check("fill_full", 32'(full0), 32'd1);
        din0 = 8'h99;
        step();
        check("extra_write_overflow", 32'(ovf0), 32'd1);
        wr0 = 0;
        step();
        check("overflow_not_sticky", 32'(ovf0), 32'd0);

        // Drain: expect 0x11..0x88 in order with one-cycle read latency
        for (int i = 0; i < 8; i++) begin
            rd0 = 1;
            step();
            check("drain_order", 32'(dout0), 32'(8'(8'h11 * (i + 1))));
        end
        rd0 = 0;
        step();

        // Read on empty with simultaneous write of 0xA5
        wr0 = 1; rd0 = 1; din0 = 8'hA5;
        step();
        check("empty_rw_underflow", 32'(unf0), 32'd1);
        check("empty_rw_count",     32'(cnt0), 32'd1);
        check("empty_rw_dout_held", 32'(dout0), 32'h88);
        wr0 = 0;
        step();
        check("read_a5", 32'(dout0), 32'hA5);
        rd0 = 0;
        step();

        // Fill to full, then 20 cycles of simultaneous write and read
        for (int i = 0; i < 8; i++) begin
            wr0 = 1; din0 = 8'($urandom);
            step();
        end
        for (int i = 0; i < 20; i++) begin
            wr0 = 1; rd0 = 1; din0 = 8'($urandom);
            step();
        end
        wr0 = 0;
        for (int i = 0; i < 9; i++) begin
            rd0 = 1;
            step();
        end
        rd0 = 0;
        step();

        // Fall-through: word written into empty FIFO appears without rd_en
        wr1 = 1; din1 = 8'h3C;
        step();
        wr1 = 0;
        check("fwft_not_empty", 32'(empty1), 32'd0);
        check("fwft_head",      32'(dout1),  32'h3C);
        step();
        check("fwft_head_hold", 32'(dout1),  32'h3C);
        rd1 = 1;
        step();
        rd1 = 0;
        check("fwft_popped_empty", 32'(empty1), 32'd1);

        // Random traffic on both instances with a reset in the middle
        for (int i = 0; i < 500; i++) begin
            wr0  = 1'($urandom_range(0, 1));
            rd0  = 1'($urandom_range(0, 1));
            din0 = 8'($urandom);
            rst0 = (i == 311);
            wr1  = 1'($urandom_range(0, 1));
            rd1  = 1'($urandom_range(0, 1));
            din1 = 8'($urandom);
            rst1 = (i == 250);
            step();
            if (i == 250) check("ft_count_after_rst", 32'(cnt1), 32'd0);
            if (i == 311) check("std_count_after_rst", 32'(cnt0), 32'd0);
        end
        idle_inputs();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
